// File: rtl/fetch_unit_if.sv
// Purpose: bundles the fetch stage's memory, redirect and decode-side signals.
// Latency: none (wiring only).
// Backpressure: outReady from decode; master = fetch unit, slave = its environment.
// Ports: imem_en/imem_addr/imem_rdata (instruction memory), PCSrc/branchTarget/
//        Jump/jumpTarget (execute redirects), outValid/outReady/outInstruction/
//        outPC4 (decode handshake).
interface fetch_unit_if;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        PCSrc;
  logic [15:0] branchTarget;
  logic        Jump;
  logic [15:0] jumpTarget;
  logic        outValid;
  logic        outReady;
  logic [15:0] outInstruction;
  logic [15:0] outPC4;

  modport master (
    output imem_en, imem_addr, outValid, outInstruction, outPC4,
    input  imem_rdata, PCSrc, branchTarget, Jump, jumpTarget, outReady
  );

  modport slave (
    input  imem_en, imem_addr, outValid, outInstruction, outPC4,
    output imem_rdata, PCSrc, branchTarget, Jump, jumpTarget, outReady
  );
endinterface

// File: rtl/fetch_unit.sv
// Purpose: instruction fetch; owns the PC, reads a synchronous imem, buffers returns.
// Latency: issue in cycle t -> data in t+1 -> outValid in t+2; 1 instr/cycle sustained.
// Backpressure: outReady low holds the head; issue stalls once buffer + inflight fill.
// Ports: clock (rising edge), reset (async active-low), bus (fetch_unit_if.master).
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd2,
  parameter int          DEPTH    = 2
) (
  input  logic          clock,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   r_pc;
  logic [CW-1:0] r_cnt;
  logic          r_inflight;
  logic          r_epoch;
  logic          r_tag_epoch;
  logic [15:0]   r_tag_addr;
  logic [15:0]   r_buf_instr [DEPTH];
  logic [15:0]   r_buf_pc4   [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;

  logic          w_redirect;
  logic [15:0]   w_target;
  logic          w_out_vld;
  logic          w_pop;
  logic [CW:0]   w_occ;
  logic          w_issue;
  logic          w_ret;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_redirect = bus.PCSrc | bus.Jump;
  assign w_target   = bus.Jump ? bus.jumpTarget : bus.branchTarget;
  assign w_out_vld  = (r_cnt != '0) & ~w_redirect;
  assign w_pop      = w_out_vld & bus.outReady;

  // Occupancy seen by a new request: buffered + the return still on its way,
  // minus the slot freed by this cycle's pop. Counting inflight here is what
  // guarantees a return always finds a free slot.
  assign w_occ   = {1'b0, r_cnt} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  // Gated by reset so the memory sees no strobe while reset is held.
  assign w_issue = reset & ~w_redirect & (w_occ < (CW+1)'(DEPTH));

  // A return is kept only if it was issued in the current epoch; a redirect in
  // the same cycle wins because the buffer is being cleared.
  assign w_ret = r_inflight & (r_tag_epoch == r_epoch) & ~w_redirect;

  assign bus.imem_en        = w_issue;
  assign bus.imem_addr      = r_pc;
  assign bus.outValid       = w_out_vld;
  assign bus.outInstruction = r_buf_instr[r_head];
  assign bus.outPC4         = r_buf_pc4[r_head];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc        <= RESET_PC;
      r_cnt       <= '0;
      r_inflight  <= 1'b0;
      r_epoch     <= 1'b0;
      r_tag_epoch <= 1'b0;
      r_tag_addr  <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_instr[i] <= '0;
        r_buf_pc4[i]   <= '0;
      end
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag_addr  <= r_pc;
        r_tag_epoch <= r_epoch;
      end

      if (w_redirect) begin
        r_pc    <= w_target;
        r_cnt   <= '0;
        // Empty the buffer without moving the head so the output data holds.
        r_tail  <= r_head;
        r_epoch <= ~r_epoch;
      end else begin
        if (w_issue) begin
          r_pc <= r_pc + PC_INC;
        end
        if (w_ret) begin
          r_buf_instr[r_tail] <= bus.imem_rdata;
          r_buf_pc4[r_tail]   <= r_tag_addr + PC_INC;
          r_tail              <= ptr_inc(r_tail);
        end
        if (w_pop) begin
          r_head <= ptr_inc(r_head);
        end
        case ({w_ret, w_pop})
          2'b10:   r_cnt <= r_cnt + CW'(1);
          2'b01:   r_cnt <= r_cnt - CW'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: directed self-checking bench for fetch_unit (two instances, RESET_PC 0 and FFFC).
// Latency: checks the t / t+1 / t+2 issue-to-valid pipeline and redirect recovery.
// Backpressure: exercises outReady stalls, full-buffer redirect and mid-flight reset.
module tb_fetch_unit;

  logic clk;
  logic rst0;
  logic rst1;
  int   n_vec;
  int   n_bad;

  fetch_unit_if u_if0 ();
  fetch_unit_if u_if1 ();

  fetch_unit #(.RESET_PC(16'h0000), .PC_INC(16'd2), .DEPTH(2)) u_dut0 (
    .clock (clk),
    .reset (rst0),
    .bus   (u_if0.master)
  );

  fetch_unit #(.RESET_PC(16'hFFFC), .PC_INC(16'd2), .DEPTH(2)) u_dut1 (
    .clock (clk),
    .reset (rst1),
    .bus   (u_if1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: instr(addr) = addr ^ A5A5, one cycle later.
  always @(posedge clk) begin
    if (u_if0.imem_en) u_if0.imem_rdata <= u_if0.imem_addr ^ 16'hA5A5;
    if (u_if1.imem_en) u_if1.imem_rdata <= u_if1.imem_addr ^ 16'hA5A5;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Move to 2 time units after the next rising edge; inputs are driven there.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst0 = 1'b0;
    rst1 = 1'b0;
    u_if0.PCSrc = 1'b0; u_if0.Jump = 1'b0;
    u_if0.branchTarget = 16'h0000; u_if0.jumpTarget = 16'h0000;
    u_if0.outReady = 1'b1;
    u_if1.PCSrc = 1'b0; u_if1.Jump = 1'b0;
    u_if1.branchTarget = 16'h0000; u_if1.jumpTarget = 16'h0000;
    u_if1.outReady = 1'b1;

    // Reset state
    tick; tick; #1;
    chk("rst_vld",   16'(u_if0.outValid), 16'h0000);
    chk("rst_en",    16'(u_if0.imem_en),  16'h0000);
    chk("rst_instr", u_if0.outInstruction, 16'h0000);
    chk("rst_pc4",   u_if0.outPC4,         16'h0000);

    // Streaming with outReady high: issue from cycle 0, first valid in cycle 2
    rst0 = 1'b1; #1;
    chk("c0_en",   16'(u_if0.imem_en),  16'h0001);
    chk("c0_addr", u_if0.imem_addr,     16'h0000);
    chk("c0_vld",  16'(u_if0.outValid), 16'h0000);
    tick; #1;
    chk("c1_addr", u_if0.imem_addr,     16'h0002);
    chk("c1_vld",  16'(u_if0.outValid), 16'h0000);
    tick; #1;
    chk("c2_vld",   16'(u_if0.outValid), 16'h0001);
    chk("c2_instr", u_if0.outInstruction, 16'hA5A5);
    chk("c2_pc4",   u_if0.outPC4,         16'h0002);
    chk("c2_addr",  u_if0.imem_addr,      16'h0004);
    tick; #1;
    chk("c3_instr", u_if0.outInstruction, 16'hA5A7);
    chk("c3_pc4",   u_if0.outPC4,         16'h0004);
    tick; #1;
    chk("c4_instr", u_if0.outInstruction, 16'hA5A1);
    chk("c4_pc4",   u_if0.outPC4,         16'h0006);

    // Stall: outReady low for 5 cycles, head held, issue stops
    tick; u_if0.outReady = 1'b0; #1;
    chk("st_vld",   16'(u_if0.outValid), 16'h0001);
    chk("st_instr", u_if0.outInstruction, 16'hA5A3);
    chk("st_pc4",   u_if0.outPC4,         16'h0008);
    chk("st_en",    16'(u_if0.imem_en),   16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick; #1;
      chk("hold_vld",   16'(u_if0.outValid), 16'h0001);
      chk("hold_instr", u_if0.outInstruction, 16'hA5A3);
      chk("hold_pc4",   u_if0.outPC4,         16'h0008);
      chk("hold_en",    16'(u_if0.imem_en),   16'h0000);
    end
    tick; u_if0.outReady = 1'b1; #1;
    chk("rel_instr", u_if0.outInstruction, 16'hA5A3);
    chk("rel_en",    16'(u_if0.imem_en),   16'h0001);
    chk("rel_addr",  u_if0.imem_addr,      16'h000A);
    tick; #1;
    chk("rel1_instr", u_if0.outInstruction, 16'hA5AD);
    chk("rel1_pc4",   u_if0.outPC4,         16'h000A);
    tick; u_if0.outReady = 1'b0; #1;
    chk("rel2_instr", u_if0.outInstruction, 16'hA5AF);
    chk("rel2_pc4",   u_if0.outPC4,         16'h000C);
    chk("rel2_en",    16'(u_if0.imem_en),   16'h0000);

    // Branch redirect while the buffer is full
    tick; u_if0.PCSrc = 1'b1; u_if0.branchTarget = 16'h0040; #1;
    chk("br_vld", 16'(u_if0.outValid), 16'h0000);
    chk("br_en",  16'(u_if0.imem_en),  16'h0000);
    tick; u_if0.PCSrc = 1'b0; u_if0.outReady = 1'b1; #1;
    chk("br1_vld",  16'(u_if0.outValid), 16'h0000);
    chk("br1_en",   16'(u_if0.imem_en),  16'h0001);
    chk("br1_addr", u_if0.imem_addr,     16'h0040);
    tick; #1;
    chk("br2_vld",  16'(u_if0.outValid), 16'h0000);
    chk("br2_addr", u_if0.imem_addr,     16'h0042);
    tick; #1;
    chk("br3_vld",   16'(u_if0.outValid), 16'h0001);
    chk("br3_instr", u_if0.outInstruction, 16'hA5E5);
    chk("br3_pc4",   u_if0.outPC4,         16'h0042);

    // Jump and branch together: jump wins
    tick;
    u_if0.PCSrc = 1'b1; u_if0.branchTarget = 16'h0100;
    u_if0.Jump  = 1'b1; u_if0.jumpTarget   = 16'h0200;
    #1;
    chk("jb_vld", 16'(u_if0.outValid), 16'h0000);
    tick; u_if0.PCSrc = 1'b0; u_if0.Jump = 1'b0; #1;
    chk("jb_en",   16'(u_if0.imem_en), 16'h0001);
    chk("jb_addr", u_if0.imem_addr,    16'h0200);
    tick; tick; #1;
    chk("jb_out_vld",   16'(u_if0.outValid), 16'h0001);
    chk("jb_out_instr", u_if0.outInstruction, 16'hA7A5);
    chk("jb_out_pc4",   u_if0.outPC4,         16'h0202);

    // Reset with a return outstanding
    tick; u_if0.outReady = 1'b0; #1;
    chk("pre_rst_vld", 16'(u_if0.outValid), 16'h0001);
    chk("pre_rst_pc4", u_if0.outPC4,        16'h0204);
    rst0 = 1'b0; #1;
    chk("mid_rst_vld", 16'(u_if0.outValid), 16'h0000);
    chk("mid_rst_en",  16'(u_if0.imem_en),  16'h0000);
    chk("mid_rst_pc4", u_if0.outPC4,        16'h0000);
    rst0 = 1'b1; u_if0.outReady = 1'b1; #1;
    chk("post_rst_en",   16'(u_if0.imem_en), 16'h0001);
    chk("post_rst_addr", u_if0.imem_addr,    16'h0000);
    tick; #1;
    chk("post_rst1_vld",  16'(u_if0.outValid), 16'h0000);
    chk("post_rst1_addr", u_if0.imem_addr,     16'h0002);
    tick; #1;
    chk("post_rst2_vld",   16'(u_if0.outValid), 16'h0001);
    chk("post_rst2_instr", u_if0.outInstruction, 16'hA5A5);
    chk("post_rst2_pc4",   u_if0.outPC4,         16'h0002);

    // PC wrap from RESET_PC = FFFC
    rst1 = 1'b1; #1;
    chk("wr0_en",   16'(u_if1.imem_en), 16'h0001);
    chk("wr0_addr", u_if1.imem_addr,    16'hFFFC);
    tick; #1;
    chk("wr1_addr", u_if1.imem_addr,     16'hFFFE);
    chk("wr1_vld",  16'(u_if1.outValid), 16'h0000);
    tick; #1;
    chk("wr2_addr",  u_if1.imem_addr,      16'h0000);
    chk("wr2_vld",   16'(u_if1.outValid),  16'h0001);
    chk("wr2_pc4",   u_if1.outPC4,         16'hFFFE);
    chk("wr2_instr", u_if1.outInstruction, 16'h5A59);
    tick; #1;
    chk("wr3_pc4",   u_if1.outPC4,         16'h0000);
    chk("wr3_instr", u_if1.outInstruction, 16'h5A5B);
    tick; #1;
    chk("wr4_pc4",   u_if1.outPC4,         16'h0002);
    chk("wr4_instr", u_if1.outInstruction, 16'hA5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
